// File: rtl/pixel_capture_fifo.sv
// Pixel capture front end for the CRT write port.
// Latches upstream pixel coordinates while pixel_valid is high, commits one
// pixel per pulse on its falling edge, range-checks it, and queues it in a
// small FIFO whose head is presented as registered wr_* outputs.
module pixel_capture_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int X_LIMIT    = 640,
  parameter int Y_LIMIT    = 480
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [9:0]                   pixel_x,
  input  logic [9:0]                   pixel_y,
  input  logic [2:0]                   pixel_brightness,
  input  logic                         pixel_valid,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [9:0]                   wr_x,
  output logic [9:0]                   wr_y,
  output logic [2:0]                   wr_brightness,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                  accepted_count,
  output logic [15:0]                  dropped_count,
  output logic [15:0]                  rejected_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 23;
  localparam logic [31:0] X_LIM = X_LIMIT;
  localparam logic [31:0] Y_LIM = Y_LIMIT;

  logic          s1, s2;
  logic [9:0]    hold_x, hold_y;
  logic [2:0]    hold_b;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [EW-1:0] mem [FIFO_DEPTH];

  logic          commit, in_range, full, pop, push, drop, reject;
  logic [LW-1:0] level_nxt, level_after_pop;
  logic [EW-1:0] head_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && v != 16'hFFFF) return v + 16'd1;
    return v;
  endfunction

  // Falling-edge detect on pixel_valid and holding register (last high sample wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      hold_x <= '0;
      hold_y <= '0;
      hold_b <= '0;
    end else begin
      s1 <= pixel_valid;
      s2 <= s1;
      if (pixel_valid) begin
        hold_x <= pixel_x;
        hold_y <= pixel_y;
        hold_b <= pixel_brightness;
      end
    end
  end

  // Push/pop decisions and next head entry; a push into an empty FIFO only
  // becomes visible after the push edge, never combinationally.
  always_comb begin
    commit          = s2 & ~s1;
    in_range        = (32'(hold_x) < X_LIM) && (32'(hold_y) < Y_LIM);
    full            = (fifo_level == LW'(FIFO_DEPTH));
    pop             = wr_valid & wr_ready;
    push            = commit & in_range & (~full | pop);
    drop            = commit & in_range & full & ~pop;
    reject          = commit & ~in_range;
    level_after_pop = fifo_level - LW'(pop);
    level_nxt       = level_after_pop + LW'(push);
    rd_ptr_nxt      = rd_ptr + AW'(pop);
    head_nxt        = {wr_x, wr_y, wr_brightness};
    if (level_after_pop != '0)
      head_nxt = mem[rd_ptr_nxt];
    else if (push)
      head_nxt = {hold_x, hold_y, hold_b};
  end

  // Entry storage; validity is defined by pointers and level only
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {hold_x, hold_y, hold_b};
  end

  // Pointers, level, registered head outputs and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      wr_valid       <= 1'b0;
      wr_x           <= '0;
      wr_y           <= '0;
      wr_brightness  <= '0;
      accepted_count <= '0;
      dropped_count  <= '0;
      rejected_count <= '0;
    end else begin
      wr_ptr         <= wr_ptr + AW'(push);
      rd_ptr         <= rd_ptr_nxt;
      fifo_level     <= level_nxt;
      wr_valid       <= (level_nxt != '0);
      {wr_x, wr_y, wr_brightness} <= head_nxt;
      accepted_count <= sat_inc(accepted_count, push);
      dropped_count  <= sat_inc(dropped_count, drop);
      rejected_count <= sat_inc(rejected_count, reject);
    end
  end

endmodule

// File: tb/tb_pixel_capture_fifo.sv
// Directed bench for pixel_capture_fifo: a vector table of single pulses
// against a stalled write port, plus hand sequences for latency, held
// pulses, full-FIFO commit with pop, drain order and async reset.
module tb_pixel_capture_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic [2:0]  pixel_brightness = '0;
  logic        pixel_valid = 1'b0;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [9:0]  wr_x, wr_y;
  logic [2:0]  wr_brightness;
  logic [3:0]  fifo_level;
  logic [15:0] accepted_count, dropped_count, rejected_count;

  int checks = 0;
  int errors = 0;

  pixel_capture_fifo #(.FIFO_DEPTH(8), .X_LIMIT(640), .Y_LIMIT(480)) dut (
    .clk(clk), .rst_n(rst_n),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_brightness(pixel_brightness), .pixel_valid(pixel_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_brightness(wr_brightness),
    .fifo_level(fifo_level),
    .accepted_count(accepted_count), .dropped_count(dropped_count),
    .rejected_count(rejected_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x, y;
    logic [2:0]  b;
    logic        ev;
    logic [9:0]  ex, ey;
    logic [2:0]  eb;
    logic [3:0]  lvl;
    logic [15:0] acc, drp, rej;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
    pixel_x = x; pixel_y = y; pixel_brightness = b; pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    tick();
    tick();
  endtask

  logic [9:0] dr_x [8];
  logic [2:0] dr_b [8];

  initial begin
    // Table: stalled write port, rejects, boundary accept, fill, overflow
    tbl[0] = '{10'd640, 10'd0,   3'd0, 1'b0, 10'd0,   10'd0,   3'd0, 4'd0, 16'd0, 16'd0, 16'd1};
    tbl[1] = '{10'd0,   10'd480, 3'd0, 1'b0, 10'd0,   10'd0,   3'd0, 4'd0, 16'd0, 16'd0, 16'd2};
    tbl[2] = '{10'd639, 10'd479, 3'd1, 1'b1, 10'd639, 10'd479, 3'd1, 4'd1, 16'd1, 16'd0, 16'd2};
    for (int k = 3; k <= 9; k++)
      tbl[k] = '{10'(k-2), 10'(2*(k-2)), 3'(k-2), 1'b1, 10'd639, 10'd479, 3'd1,
                 4'(k-1), 16'(k-1), 16'd0, 16'd2};
    tbl[10] = '{10'd8, 10'd16, 3'd0, 1'b1, 10'd639, 10'd479, 3'd1, 4'd8, 16'd8, 16'd1, 16'd2};
    tbl[11] = '{10'd9, 10'd18, 3'd1, 1'b1, 10'd639, 10'd479, 3'd1, 4'd8, 16'd8, 16'd2, 16'd2};
    for (int k = 0; k < 7; k++) begin
      dr_x[k] = 10'(k+1);
      dr_b[k] = 3'(k+1);
    end
    dr_x[7] = 10'd20;
    dr_b[7] = 3'd3;

    // Reset state
    #1;
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_wr_x", 32'(wr_x), 0);
    chk("rst_acc", 32'(accepted_count), 0);
    #11 rst_n = 1'b1;
    tick();

    // Single-cycle pulse latency with write port ready
    wr_ready = 1'b1;
    pixel_x = 10'd100; pixel_y = 10'd50; pixel_brightness = 3'd5; pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    tick();
    chk("lat_early_valid", 32'(wr_valid), 0);
    tick();
    chk("lat_valid", 32'(wr_valid), 1);
    chk("lat_x", 32'(wr_x), 100);
    chk("lat_y", 32'(wr_y), 50);
    chk("lat_b", 32'(wr_brightness), 5);
    chk("lat_acc", 32'(accepted_count), 1);
    tick();
    chk("lat_popped_valid", 32'(wr_valid), 0);
    chk("lat_popped_level", 32'(fifo_level), 0);

    // Held pulse: one entry, last sample wins
    wr_ready = 1'b0;
    pixel_y = 10'd7; pixel_brightness = 3'd2; pixel_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pixel_x = 10'(10 + k);
      tick();
    end
    pixel_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("held_level", 32'(fifo_level), 1);
    chk("held_x", 32'(wr_x), 13);
    chk("held_acc", 32'(accepted_count), 2);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    chk("held_drained", 32'(fifo_level), 0);

    // Clean start for the table
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      pulse(tbl[i].x, tbl[i].y, tbl[i].b);
      chk($sformatf("v%0d_valid", i), 32'(wr_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
      chk($sformatf("v%0d_acc", i), 32'(accepted_count), 32'(tbl[i].acc));
      chk($sformatf("v%0d_drp", i), 32'(dropped_count), 32'(tbl[i].drp));
      chk($sformatf("v%0d_rej", i), 32'(rejected_count), 32'(tbl[i].rej));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_x", i), 32'(wr_x), 32'(tbl[i].ex));
        chk($sformatf("v%0d_y", i), 32'(wr_y), 32'(tbl[i].ey));
        chk($sformatf("v%0d_b", i), 32'(wr_brightness), 32'(tbl[i].eb));
      end
    end

    // Full FIFO: commit coinciding with a pop is accepted
    pixel_x = 10'd20; pixel_y = 10'd40; pixel_brightness = 3'd3; pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    tick();
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    chk("fullpop_level", 32'(fifo_level), 8);
    chk("fullpop_drp", 32'(dropped_count), 2);
    chk("fullpop_acc", 32'(accepted_count), 9);
    chk("fullpop_head", 32'(wr_x), 1);

    // Drain in order
    wr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(wr_valid), 1);
      chk($sformatf("drain%0d_x", k), 32'(wr_x), 32'(dr_x[k]));
      chk($sformatf("drain%0d_b", k), 32'(wr_brightness), 32'(dr_b[k]));
      tick();
    end
    chk("drain_empty_valid", 32'(wr_valid), 0);
    chk("drain_empty_level", 32'(fifo_level), 0);
    tick();
    chk("ready_idle_level", 32'(fifo_level), 0);
    wr_ready = 1'b0;

    // Async reset mid-stream with 3 entries queued
    for (int k = 0; k < 3; k++) pulse(10'(30 + k), 10'd1, 3'd1);
    chk("pre_rst_level", 32'(fifo_level), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(wr_valid), 0);
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_acc", 32'(accepted_count), 0);
    chk("arst_drp", 32'(dropped_count), 0);
    chk("arst_rej", 32'(rejected_count), 0);

    // pixel_valid high across reset release commits only after it falls
    pixel_x = 10'd40; pixel_y = 10'd41; pixel_brightness = 3'd2; pixel_valid = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("rel_high_level", 32'(fifo_level), 0);
    pixel_valid = 1'b0;
    tick();
    tick();
    chk("rel_fall_level", 32'(fifo_level), 1);
    chk("rel_fall_x", 32'(wr_x), 40);
    chk("rel_fall_acc", 32'(accepted_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
